// File: rtl/bsmem_pkg.sv
// bsmem_pkg: shared types and constants for the scratch-memory arbiter
package bsmem_pkg;
    typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_e;
    typedef enum logic [1:0] {IDLE, PEND, HOLD} arb_state_e;
    localparam int LANES = 4;
endpackage

// File: rtl/bsmem_rr_arb.sv
// bsmem_rr_arb: two-input round-robin arbiter; bit 0 is fetch, bit 1 is data
module bsmem_rr_arb
    import bsmem_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] valid_i,
    input  logic       en_i,
    output logic [1:0] grant_o
);
    owner_e last_q, last_d;
    always_comb begin
        grant_o = (valid_i == 2'b11) ? ((last_q == OWN_D) ? 2'b01 : 2'b10) : valid_i;
        last_d  = (en_i && |grant_o) ? (grant_o[1] ? OWN_D : OWN_IF) : last_q;
    end
    // Starting from "data" lets fetch win the first conflict
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) last_q <= OWN_D;
        else       last_q <= last_d;
    end
endmodule

// File: rtl/bsmem_arbiter.sv
// bsmem_arbiter: shares a 1-cycle-read scratch memory between fetch and data ports,
// realigning read timing and holding one response under consumer backpressure
module bsmem_arbiter
    import bsmem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_valid_i,
    output logic              if_req_ready_o,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_resp_valid_o,
    input  logic              if_resp_ready_i,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              d_req_valid_i,
    output logic              d_req_ready_o,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic              d_we_i,
    input  logic [LANES-1:0]  d_wstrb_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_resp_valid_o,
    input  logic              d_resp_ready_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_enable_o,
    output logic [LANES-1:0]  mem_wstrb_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [ADDR_W-1:0] mem_addr_prev_o,
    output logic [DATA_W-1:0] mem_wvalue_o,
    input  logic [DATA_W-1:0] mem_rvalue_i
);
    arb_state_e        state_q, state_d;
    owner_e            own_q, own_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [ADDR_W-1:0] addr_prev_q;
    logic [1:0]        gnt;
    logic              resp_v, resp_take, can_issue, rd_gnt;
    logic [DATA_W-1:0] resp_data;

    assign resp_v    = state_q != IDLE;
    assign resp_data = (state_q == HOLD) ? hold_q : mem_rvalue_i;
    assign resp_take = resp_v && ((own_q == OWN_D) ? d_resp_ready_i : if_resp_ready_i);
    // A new grant may only issue if the slot it will need next cycle is free
    assign can_issue = !rst_i && (state_q == IDLE || resp_take);
    assign rd_gnt    = gnt[0] || (gnt[1] && !d_we_i);

    bsmem_rr_arb u_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i ({d_req_valid_i, if_req_valid_i} & {2{can_issue}}),
        .en_i    (can_issue),
        .grant_o (gnt)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = rd_gnt ? PEND : (state_q == IDLE || resp_take) ? IDLE : HOLD;
        own_d   = rd_gnt ? (gnt[1] ? OWN_D : OWN_IF) : own_q;
        hold_d  = (state_q == PEND) ? mem_rvalue_i : hold_q;
    end

    always_comb begin
        if_req_ready_o  = gnt[0];
        d_req_ready_o   = gnt[1];
        if_resp_valid_o = resp_v && own_q == OWN_IF;
        d_resp_valid_o  = resp_v && own_q == OWN_D;
        if_rdata_o      = if_resp_valid_o ? resp_data : '0;
        d_rdata_o       = d_resp_valid_o ? resp_data : '0;
        mem_addr_o      = gnt[0] ? if_addr_i : gnt[1] ? d_addr_i : addr_prev_q;
        mem_enable_o    = gnt[1] && d_we_i;
        mem_wstrb_o     = mem_enable_o ? d_wstrb_i : '0;
        mem_wvalue_o    = d_wdata_i;
        mem_addr_prev_o = addr_prev_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            own_q       <= OWN_IF;
            hold_q      <= '0;
            addr_prev_q <= '0;
        end else begin
            own_q       <= own_d;
            hold_q      <= hold_d;
            addr_prev_q <= mem_addr_o;
        end
    end
endmodule

// File: tb/tb_bsmem_arbiter.sv
// tb_bsmem_arbiter: table-driven handshake checks plus an in-order response scoreboard
module tb_bsmem_arbiter;
    import bsmem_pkg::*;

    logic        clk = 1'b0, rst = 1'b1;
    logic        if_req_valid, if_req_ready, if_resp_valid, if_resp_ready;
    logic [31:0] if_addr, if_rdata;
    logic        d_req_valid, d_req_ready, d_we, d_resp_valid, d_resp_ready;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wstrb, mem_wstrb;
    logic        mem_enable;
    logic [31:0] mem_addr, mem_addr_prev, mem_wvalue, mem_rv;

    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    bsmem_arbiter dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_valid_i(if_req_valid), .if_req_ready_o(if_req_ready), .if_addr_i(if_addr),
        .if_resp_valid_o(if_resp_valid), .if_resp_ready_i(if_resp_ready), .if_rdata_o(if_rdata),
        .d_req_valid_i(d_req_valid), .d_req_ready_o(d_req_ready), .d_addr_i(d_addr),
        .d_we_i(d_we), .d_wstrb_i(d_wstrb), .d_wdata_i(d_wdata),
        .d_resp_valid_o(d_resp_valid), .d_resp_ready_i(d_resp_ready), .d_rdata_o(d_rdata),
        .mem_enable_o(mem_enable), .mem_wstrb_o(mem_wstrb), .mem_addr_o(mem_addr),
        .mem_addr_prev_o(mem_addr_prev), .mem_wvalue_o(mem_wvalue), .mem_rvalue_i(mem_rv)
    );

    // Memory model (phys, driven by DUT outputs) and reference model (refm, driven by requester intent)
    logic [7:0] phys [0:4095];
    logic [7:0] refm [0:4095];

    function automatic logic [31:0] phys_rd(input logic [31:0] a);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = phys[a[11:0] + 12'(k)];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = refm[a[11:0] + 12'(k)];
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_enable)
            for (int k = 0; k < 4; k++)
                if (mem_wstrb[k]) phys[mem_addr[11:0] + 12'(k)] = mem_wvalue[8*k +: 8];
        mem_rv <= phys_rd(mem_addr);
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    task automatic flag(input string n);
        tests++;
        fails++;
        $display("FAIL %s: response with no outstanding read", n);
    endtask

    typedef struct packed {
        owner_e      own;
        logic [31:0] data;
    } exp_t;
    exp_t q[$];

    always @(negedge clk) begin
        if (rst) q.delete();
        else begin
            if (if_resp_valid && d_resp_valid) flag("both_resp_valid");
            if (if_resp_valid) begin
                if (q.size() == 0) flag("if_resp_spurious");
                else begin
                    chk("if_resp_owner", 32'(q[0].own), 32'(OWN_IF));
                    chk("if_rdata", if_rdata, q[0].data);
                    if (if_resp_ready) void'(q.pop_front());
                end
            end
            if (d_resp_valid) begin
                if (q.size() == 0) flag("d_resp_spurious");
                else begin
                    chk("d_resp_owner", 32'(q[0].own), 32'(OWN_D));
                    chk("d_rdata", d_rdata, q[0].data);
                    if (d_resp_ready) void'(q.pop_front());
                end
            end
            if (if_req_valid && if_req_ready) q.push_back(exp_t'{OWN_IF, ref_rd(if_addr)});
            if (d_req_valid && d_req_ready) begin
                if (d_we) begin
                    for (int k = 0; k < 4; k++)
                        if (d_wstrb[k]) refm[d_addr[11:0] + 12'(k)] = d_wdata[8*k +: 8];
                end else q.push_back(exp_t'{OWN_D, ref_rd(d_addr)});
            end
        end
    end

    // exp = {if_req_ready, d_req_ready, mem_enable, if_resp_valid, d_resp_valid}
    typedef struct packed {
        logic        if_v;
        logic [31:0] if_a;
        logic        if_rr;
        logic        d_v;
        logic        d_we;
        logic [31:0] d_a;
        logic [3:0]  d_s;
        logic [31:0] d_w;
        logic        d_rr;
        logic [4:0]  exp;
    } vec_t;

    function automatic vec_t mk(input logic iv, input logic [31:0] ia, input logic irr,
                                input logic dv, input logic dwe, input logic [31:0] da,
                                input logic [3:0] ds, input logic [31:0] dw, input logic drr,
                                input logic [4:0] e);
        return vec_t'{iv, ia, irr, dv, dwe, da, ds, dw, drr, e};
    endfunction

    task automatic drive(input vec_t v);
        if_req_valid  = v.if_v;  if_addr = v.if_a;  if_resp_ready = v.if_rr;
        d_req_valid   = v.d_v;   d_we = v.d_we;     d_addr = v.d_a;
        d_wstrb       = v.d_s;   d_wdata = v.d_w;   d_resp_ready = v.d_rr;
    endtask

    localparam int NV = 26;
    vec_t vecs [NV];
    vec_t idle;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            phys[i] = 8'(i * 37 + 5);
            refm[i] = 8'(i * 37 + 5);
        end
        idle = mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 5'b00000);
        vecs[0]  = mk(1, 32'h100, 1, 1, 0, 32'h204, 0, 0, 1, 5'b10000);
        vecs[1]  = mk(0, 0, 1, 1, 0, 32'h204, 0, 0, 1, 5'b01010);
        vecs[2]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 5'b00001);
        vecs[3]  = mk(0, 0, 1, 1, 1, 32'h403, 4'hF, 32'h12345678, 1, 5'b01100);
        vecs[4]  = mk(0, 0, 1, 1, 0, 32'h403, 0, 0, 1, 5'b01000);
        vecs[5]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 5'b00001);
        vecs[6]  = mk(1, 32'h10, 1, 0, 0, 0, 0, 0, 1, 5'b10000);
        vecs[7]  = mk(0, 0, 0, 1, 0, 32'h20, 0, 0, 1, 5'b00010);
        vecs[8]  = mk(0, 0, 0, 1, 0, 32'h20, 0, 0, 1, 5'b00010);
        vecs[9]  = mk(0, 0, 0, 1, 0, 32'h20, 0, 0, 1, 5'b00010);
        vecs[10] = mk(0, 0, 1, 1, 0, 32'h20, 0, 0, 1, 5'b01010);
        vecs[11] = mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 5'b00001);
        vecs[12] = mk(1, 32'h0, 1, 0, 0, 0, 0, 0, 1, 5'b10000);
        vecs[13] = mk(1, 32'h4, 1, 0, 0, 0, 0, 0, 1, 5'b10010);
        vecs[14] = mk(1, 32'h8, 1, 0, 0, 0, 0, 0, 1, 5'b10010);
        vecs[15] = mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 5'b00010);
        vecs[16] = mk(1, 32'h30, 1, 1, 0, 32'h34, 0, 0, 1, 5'b01000);
        vecs[17] = mk(1, 32'h30, 1, 1, 0, 32'h38, 0, 0, 1, 5'b10001);
        vecs[18] = mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 5'b00010);
        vecs[19] = mk(0, 0, 1, 1, 0, 32'h50, 0, 0, 0, 5'b01000);
        vecs[20] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 5'b00001);
        vecs[21] = mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 5'b00001);
        vecs[22] = mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 5'b00000);
        vecs[23] = mk(0, 0, 1, 1, 1, 32'h600, 4'b0101, 32'hAABBCCDD, 1, 5'b01100);
        vecs[24] = mk(0, 0, 1, 1, 0, 32'h600, 0, 0, 1, 5'b01000);
        vecs[25] = mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 5'b00001);

        // Reset state, with requests pending on both ports
        drive(vecs[0]);
        #12;
        chk("rst_if_ready", 32'(if_req_ready), 0);
        chk("rst_d_ready", 32'(d_req_ready), 0);
        chk("rst_resp_valid", {30'd0, if_resp_valid, d_resp_valid}, 0);
        chk("rst_mem_enable", 32'(mem_enable), 0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_addr_prev", mem_addr_prev, 0);
        chk("rst_rdata", if_rdata | d_rdata, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            @(negedge clk);
            chk($sformatf("row%0d_if_ready", i), 32'(if_req_ready), 32'(vecs[i].exp[4]));
            chk($sformatf("row%0d_d_ready", i), 32'(d_req_ready), 32'(vecs[i].exp[3]));
            chk($sformatf("row%0d_mem_enable", i), 32'(mem_enable), 32'(vecs[i].exp[2]));
            chk($sformatf("row%0d_if_resp_valid", i), 32'(if_resp_valid), 32'(vecs[i].exp[1]));
            chk($sformatf("row%0d_d_resp_valid", i), 32'(d_resp_valid), 32'(vecs[i].exp[0]));
            if (i == 1) begin
                chk("prev_addr_after_fetch", mem_addr_prev, 32'h100);
                chk("mem_addr_data_grant", mem_addr, 32'h204);
            end
            if (i == 3) chk("full_wstrb", 32'(mem_wstrb), 32'hF);
            if (i == 5) chk("read_after_write", d_rdata, 32'h12345678);
            if (i == 23) chk("partial_wstrb", 32'(mem_wstrb), 32'h5);
            if (i == 25) chk("partial_write_read", d_rdata, 32'h74BB2ADD);
            @(posedge clk); #1;
        end

        // Asynchronous reset while a fetch read is in flight
        drive(mk(1, 32'h70, 1, 0, 0, 0, 0, 0, 1, 5'b00000));
        @(posedge clk); #1;
        drive(mk(1, 32'h74, 1, 1, 0, 32'h78, 0, 0, 1, 5'b00000));
        #2;
        chk("pre_rst_if_resp_valid", 32'(if_resp_valid), 1);
        chk("pre_rst_d_ready", 32'(d_req_ready), 1);
        rst = 1'b1;
        #1;
        chk("async_rst_if_resp_valid", 32'(if_resp_valid), 0);
        chk("async_rst_d_ready", 32'(d_req_ready), 0);
        chk("async_rst_if_ready", 32'(if_req_ready), 0);
        drive(idle);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst_no_resp%0d", i), {30'd0, if_resp_valid, d_resp_valid}, 0);
            @(posedge clk); #1;
        end
        drive(mk(1, 32'h80, 1, 1, 0, 32'h84, 0, 0, 1, 5'b00000));
        @(negedge clk);
        chk("post_rst_fetch_wins_if", 32'(if_req_ready), 1);
        chk("post_rst_fetch_wins_d", 32'(d_req_ready), 0);
        @(posedge clk); #1;
        drive(mk(0, 0, 1, 1, 0, 32'h84, 0, 0, 1, 5'b00000));
        @(negedge clk);
        chk("post_rst_d_grant", 32'(d_req_ready), 1);
        @(posedge clk); #1;
        drive(idle);
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bsmem_arbiter.md
Name: bsmem_arbiter

Overview:
- Two-requester controller for the byte-striped, unaligned-capable scratch memory (single port, 1-cycle registered read).
- Shares the memory between an instruction-fetch port (read-only) and a data port (read/write). Arbitration is round-robin.
- Drives the memory's enable/strobe/address/previous-address inputs and realigns the read-data timing.
- Buffers read responses under consumer backpressure, because memory read data is overwritten every cycle.

Parameters:
- ADDR_W, 32, requester/memory address width.
- DATA_W, 32, data width; fixed at 32 (the memory is 4 byte lanes).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- if_req_valid_i  in  1  fetch request valid.
- if_req_ready_o  out  1  fetch request accepted this cycle.
- if_addr_i  in  ADDR_W  fetch byte address (any alignment).
- if_resp_valid_o  out  1  fetch read data valid.
- if_resp_ready_i  in  1  fetch consumer accepts data.
- if_rdata_o  out  DATA_W  fetch read data.
- d_req_valid_i  in  1  data request valid.
- d_req_ready_o  out  1  data request accepted this cycle.
- d_addr_i  in  ADDR_W  data byte address.
- d_we_i  in  1  1 = write, 0 = read.
- d_wstrb_i  in  4  byte strobes in requester byte order.
- d_wdata_i  in  DATA_W  write data.
- d_resp_valid_o  out  1  data read data valid (reads only).
- d_resp_ready_i  in  1  data consumer accepts data.
- d_rdata_o  out  DATA_W  data read data.
- mem_enable_o  out  1  memory write enable.
- mem_wstrb_o  out  4  memory strobes.
- mem_addr_o  out  ADDR_W  memory address.
- mem_addr_prev_o  out  ADDR_W  address issued in the previous cycle.
- mem_wvalue_o  out  DATA_W  memory write data.
- mem_rvalue_i  in  DATA_W  memory read data, valid the cycle after issue.

Behaviour:
- Reset (async, rst_i=1): all *_ready_o, *_resp_valid_o and mem_enable_o are 0. mem_wstrb_o=0, mem_addr_o=0, mem_addr_prev_o=0, rdata outputs=0. Pending-read flag, hold buffer and last-grant pointer are cleared; the last-grant pointer resets to "data", so fetch wins the first conflict.
- Issue condition: no read pending into a full hold buffer, i.e. hold_valid=0, or the hold buffer is being drained this cycle.
- Grant:
  - One requester valid → that requester is granted.
  - Both valid → the one not granted last wins; the pointer updates on every grant.
  - *_req_ready_o = grant. Ready is combinational from valid and state.
- Memory drive (combinational from grant):
  - mem_addr_o = granted address, otherwise holds the last issued address.
  - mem_enable_o = grant & d_we_i. mem_wstrb_o = d_wstrb_i on a data write, else 0.
  - mem_wvalue_o = d_wdata_i.
- mem_addr_prev_o: register loaded with mem_addr_o every cycle, so the memory realigns read data with the address it captured.
- Write: completes on grant, no response. A data read to the same address in the next cycle returns the new data (the memory writes at the clock edge).
- Read latency: a granted read sets pending (with owner) for the next cycle; mem_rvalue_i is sampled in that cycle.
  - If the owner's hold buffer is empty: present combinationally. *_resp_valid_o=1, rdata=mem_rvalue_i.
  - If resp_ready=0: capture into the hold buffer (one entry, with owner). Subsequent cycles output from the hold buffer.
  - Minimum latency: grant in cycle N, data in cycle N+1.
- Hold buffer full: all grants are blocked. Exception: same-cycle drain (resp_ready=1), which permits issue. Throughput is 1 op/cycle when consumers are always ready.
- Ordering: responses are returned strictly in issue order. At most one read is pending plus one held.
- Simultaneous: a pending read completing, a hold drain, and a new grant in the same cycle are all legal. The new read's data arrives the following cycle.
- Reset mid-operation drops pending and held responses; no response is emitted after reset.
- Arbiter state machine: IDLE (nothing pending), PEND (read in flight), HOLD (buffer full, grants blocked).
  - IDLE → PEND on a read grant.
  - PEND → IDLE if the response is consumed and there is no new read.
  - PEND → PEND if the response is consumed and there is a new read.
  - PEND → HOLD if the response is not consumed.
  - HOLD → IDLE/PEND on drain, depending on a concurrent grant.

Decomposition:
- Package bsmem_pkg:
  - owner_e {OWN_IF, OWN_D}
  - arb_state_e {IDLE, PEND, HOLD}
  - LANES=4 constant
- Sub-module bsmem_rr_arb: 2-input round-robin arbiter (valid in, grant out, enable-to-update pointer). Everything else stays in the top level.

Test Plan:
- After reset, both requesters valid, reads at 0x100 (fetch) and 0x204 (data) → fetch granted in cycle 1 and data in cycle 2. if_rdata = mem[0x100] in cycle 2, d_rdata in cycle 3. mem_addr_prev_o = 0x100 in cycle 2.
- Data write 0x12345678 to 0x403 with wstrb=4'b1111, then read 0x403 next cycle → d_rdata=0x12345678 one cycle after the read grant. mem_enable_o=1 only in the write cycle.
- Fetch read 0x10 with if_resp_ready_i=0 for 3 cycles → if_resp_valid_o stays 1 with constant data. d_req_ready_o=0 throughout. When ready rises, data is accepted and data grant resumes in that same cycle.
- Back-to-back fetch reads 0x0, 0x4, 0x8 with resp_ready always 1 → one grant per cycle; responses in order, each at latency 1.
- Assert rst_i asynchronously while a read is pending → all valid/ready outputs drop immediately. No response appears after rst_i deasserts. Fetch wins the next conflict.
